// File: rtl/graphics_core_pkg.sv
// Shared constants and FSM state type for the frame-composition core.
// Default geometry is 640x480; instances may override it through parameters.
package graphics_core_pkg;

  localparam int unsigned HOR_DEFAULT          = 640;
  localparam int unsigned VER_DEFAULT          = 480;
  localparam int unsigned SYMBOL_WIDTH_DEFAULT = 7;
  localparam int unsigned CELL_WIDTH_DEFAULT   = 8;

  localparam int unsigned X_WIDTH_DEFAULT      = $clog2(HOR_DEFAULT);
  localparam int unsigned Y_WIDTH_DEFAULT      = $clog2(VER_DEFAULT);
  localparam int unsigned PIXELS_DEFAULT       = HOR_DEFAULT * VER_DEFAULT;
  localparam int unsigned ADDR_WIDTH_DEFAULT   = $clog2(PIXELS_DEFAULT);

  typedef enum logic [2:0] {
    FILL_START,
    FILL_WAIT,
    SYM_REQ,
    SYM_CHECK,
    SYM_WAIT,
    LOGIC_START,
    LOGIC_WAIT,
    WAIT_SWAP
  } state_e;

endpackage

// File: rtl/graphics_core_if.sv
// Bus between the graphics core and its neighbours: scan-out reader, drawers,
// text buffer and plot logic. master = environment side, slave = core side.
interface graphics_core_if
  import graphics_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
  parameter int unsigned X_WIDTH      = X_WIDTH_DEFAULT,
  parameter int unsigned Y_WIDTH      = Y_WIDTH_DEFAULT,
  parameter int unsigned SYMBOL_WIDTH = SYMBOL_WIDTH_DEFAULT
) ();

  logic                    swap;
  logic [ADDR_WIDTH-1:0]   read_addr;
  logic                    read_data;
  logic                    ext_write_enable;
  logic [ADDR_WIDTH-1:0]   ext_write_addr;
  logic                    ext_write_data;
  logic                    visible_iter_en;
  logic [SYMBOL_WIDTH-1:0] symbol;
  logic                    symbol_valid;
  logic                    symbol_drawer_start;
  logic                    symbol_drawer_ready;
  logic [X_WIDTH-1:0]      symbol_drawer_x;
  logic [Y_WIDTH-1:0]      symbol_drawer_y;
  logic                    logic_start;
  logic                    logic_ready;
  logic                    frame_done;

  modport master (
    output swap, read_addr, ext_write_enable, ext_write_addr, ext_write_data,
           symbol, symbol_valid, symbol_drawer_ready, logic_ready,
    input  read_data, visible_iter_en, symbol_drawer_start, symbol_drawer_x,
           symbol_drawer_y, logic_start, frame_done
  );

  modport slave (
    input  swap, read_addr, ext_write_enable, ext_write_addr, ext_write_data,
           symbol, symbol_valid, symbol_drawer_ready, logic_ready,
    output read_data, visible_iter_en, symbol_drawer_start, symbol_drawer_x,
           symbol_drawer_y, logic_start, frame_done
  );

endinterface

// File: rtl/graphics_core_clear_engine.sv
// Fill engine: on start, writes 0 to every pixel address in order, one per cycle.
// Outputs are all-zero while idle so they can be OR-merged with other writers.
module clear_engine
  import graphics_core_pkg::*;
#(
  parameter int unsigned PIXELS_COUNT = PIXELS_DEFAULT,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  write_data
);

  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    busy_d = busy_q;
    addr_d = addr_q;
    if (busy_q) begin
      if (addr_q == ADDR_WIDTH'(PIXELS_COUNT - 1)) begin
        busy_d = 1'b0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end else if (start) begin
      busy_d = 1'b1;
      addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      addr_q <= '0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
    end
  end

  // addr_q returns to 0 at the end of a fill, so the idle address is already zero
  assign ready        = ~busy_q;
  assign write_enable = busy_q;
  assign write_addr   = addr_q;
  assign write_data   = 1'b0;

endmodule

// File: rtl/graphics_core.sv
// Frame-composition core: double-buffered 1-bit frame buffer, clear engine and
// the per-frame sequencer (clear, draw text row, run plot logic, wait for swap).
module graphics_core
  import graphics_core_pkg::*;
#(
  parameter int unsigned HOR_ACTIVE_PIXELS = HOR_DEFAULT,
  parameter int unsigned VER_ACTIVE_PIXELS = VER_DEFAULT,
  parameter int unsigned SYMBOL_WIDTH      = SYMBOL_WIDTH_DEFAULT,
  parameter int unsigned CELL_WIDTH        = CELL_WIDTH_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  graphics_core_if.slave bus
);

  localparam int unsigned X_WIDTH      = $clog2(HOR_ACTIVE_PIXELS);
  localparam int unsigned PIXELS_COUNT = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int unsigned ADDR_WIDTH   = $clog2(PIXELS_COUNT);

  state_e             state_q, state_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic               bank_q, bank_d;
  logic               settle_q, settle_d;
  logic               read_data_q, read_data_d;

  logic                  fill_start, fill_ready, fill_we, fill_data;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic                  wr_en, wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  iter_en, sd_start, l_start;
  int unsigned           next_x;

  logic frame_mem [2][PIXELS_COUNT];

  clear_engine #(
    .PIXELS_COUNT (PIXELS_COUNT),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_clear (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (fill_start),
    .ready        (fill_ready),
    .write_enable (fill_we),
    .write_addr   (fill_addr),
    .write_data   (fill_data)
  );

  assign wr_en   = fill_we   | bus.ext_write_enable;
  assign wr_addr = fill_addr | bus.ext_write_addr;
  assign wr_data = fill_data | bus.ext_write_data;

  always_ff @(posedge clk) begin
    if (wr_en) frame_mem[~bank_q][wr_addr] <= wr_data;
  end

  assign read_data_d = frame_mem[bank_q][bus.read_addr];

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    bank_d     = bank_q;
    settle_d   = 1'b0;
    fill_start = 1'b0;
    iter_en    = 1'b0;
    sd_start   = 1'b0;
    l_start    = 1'b0;
    next_x     = x_q + CELL_WIDTH;
    case (state_q)
      FILL_START: begin
        fill_start = 1'b1;
        state_d    = FILL_WAIT;
      end
      FILL_WAIT: begin
        x_d = '0;
        if (fill_ready) state_d = SYM_REQ;
      end
      SYM_REQ: begin
        iter_en = 1'b1;
        state_d = SYM_CHECK;
      end
      SYM_CHECK: begin
        if (bus.symbol_valid) begin
          sd_start = 1'b1;
          settle_d = 1'b1;
          state_d  = SYM_WAIT;
        end else begin
          state_d = LOGIC_START;
        end
      end
      // settle_q skips the first wait cycle, before the drawer has dropped ready
      SYM_WAIT: begin
        if (!settle_q && bus.symbol_drawer_ready) begin
          if (next_x + CELL_WIDTH > HOR_ACTIVE_PIXELS) begin
            state_d = LOGIC_START;
          end else begin
            x_d     = X_WIDTH'(next_x);
            state_d = SYM_REQ;
          end
        end
      end
      LOGIC_START: begin
        l_start  = 1'b1;
        settle_d = 1'b1;
        state_d  = LOGIC_WAIT;
      end
      LOGIC_WAIT: begin
        if (!settle_q && bus.logic_ready) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (bus.swap) begin
          bank_d  = ~bank_q;
          state_d = FILL_START;
        end
      end
      default: state_d = FILL_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL_START;
      x_q         <= '0;
      bank_q      <= 1'b0;
      settle_q    <= 1'b0;
      read_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      bank_q      <= bank_d;
      settle_q    <= settle_d;
      read_data_q <= read_data_d;
    end
  end

  assign bus.read_data           = read_data_q;
  assign bus.visible_iter_en     = iter_en;
  assign bus.symbol_drawer_start = sd_start;
  assign bus.symbol_drawer_x     = x_q;
  assign bus.symbol_drawer_y     = '0;
  assign bus.logic_start         = l_start;
  assign bus.frame_done          = (state_q == WAIT_SWAP);

endmodule

// File: tb/tb_graphics_core.sv
// Directed bench for graphics_core on a reduced 32x4 frame (128 pixels, 4 text cells).
module tb_graphics_core;

  localparam int HOR = 32;
  localparam int VER = 4;
  localparam int PIX = HOR * VER;
  localparam int AW  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  graphics_core_if #(
    .ADDR_WIDTH   (AW),
    .X_WIDTH      (5),
    .Y_WIDTH      (2),
    .SYMBOL_WIDTH (7)
  ) bus ();

  graphics_core #(
    .HOR_ACTIVE_PIXELS (HOR),
    .VER_ACTIVE_PIXELS (VER),
    .SYMBOL_WIDTH      (7),
    .CELL_WIDTH        (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Fill-write observer: addresses must run 0,1,2,... with data 0
  int          fill_bad = 0;
  int          fill_len = 0;
  int          last_len = 0;
  logic        prev_we  = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we  = 1'b0;
      fill_len = 0;
    end else begin
      if (u_dut.fill_we) begin
        if (u_dut.fill_data !== 1'b0) fill_bad++;
        if (!prev_we && u_dut.fill_addr !== '0) fill_bad++;
        if (prev_we && u_dut.fill_addr !== AW'(prev_addr + 1'b1)) fill_bad++;
        fill_len++;
      end else if (prev_we) begin
        last_len = fill_len;
        fill_len = 0;
      end
      prev_we   = u_dut.fill_we;
      prev_addr = u_dut.fill_addr;
    end
  end

  int xs [8];
  logic [31:0] ys_or;

  task automatic wait_iter(input int swap_at, output int cyc);
    cyc = 0;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus.visible_iter_en) return;
      bus.swap = (cyc == swap_at);
    end
    bus.swap = 1'b0;
    check("iter_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_text(input int n_valid, input int stop_at,
                          output int n_start, output int n_iter, output int n_ls);
    int busy;
    busy = 0; n_start = 0; n_iter = 0; n_ls = 0; ys_or = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (bus.visible_iter_en) begin
        bus.symbol_valid = (n_iter < n_valid);
        bus.symbol       = 7'(7'h41 + n_iter);
        n_iter++;
      end
      if (bus.symbol_drawer_start) begin
        if (n_start < 8) xs[n_start] = int'(bus.symbol_drawer_x);
        ys_or = ys_or | 32'(bus.symbol_drawer_y);
        n_start++;
        if (n_start == stop_at) return;
        bus.symbol_drawer_ready = 1'b0;
        busy = 3;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) bus.symbol_drawer_ready = 1'b1;
      end
      if (bus.logic_start) begin
        n_ls++;
        bus.symbol_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("text_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_logic(input int hold, input int waddr);
    int seen;
    seen = 0;
    bus.logic_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.logic_start) seen++;
      bus.ext_write_enable = (i == 2);
      bus.ext_write_addr   = (i == 2) ? AW'(waddr) : '0;
      bus.ext_write_data   = (i == 2);
    end
    bus.ext_write_enable = 1'b0;
    bus.ext_write_addr   = '0;
    bus.ext_write_data   = 1'b0;
    check("logic_restart", seen, 0);
    check("done_early", bus.frame_done, 0);
    bus.logic_ready = 1'b1;
    @(negedge clk);
    check("done_latency", bus.frame_done, 1);
  endtask

  task automatic read_check(input int addr, input int exp, input string tag);
    bus.read_addr = AW'(addr);
    @(negedge clk);
    check(tag, bus.read_data, exp);
  endtask

  task automatic do_swap();
    bus.swap = 1'b1;
    @(negedge clk);
    bus.swap = 1'b0;
    check("done_after_swap", bus.frame_done, 0);
  endtask

  int c, ns, ni, nl;

  initial begin
    bus.swap = 1'b0; bus.read_addr = '0;
    bus.ext_write_enable = 1'b0; bus.ext_write_addr = '0; bus.ext_write_data = 1'b0;
    bus.symbol = '0; bus.symbol_valid = 1'b0;
    bus.symbol_drawer_ready = 1'b1; bus.logic_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_iter", bus.visible_iter_en, 0);
    check("rst_sd_start", bus.symbol_drawer_start, 0);
    check("rst_logic_start", bus.logic_start, 0);
    check("rst_x", bus.symbol_drawer_x, 0);
    check("rst_y", bus.symbol_drawer_y, 0);
    check("rst_read_data", bus.read_data, 0);

    // Frame 1: fill, three symbols, long plot phase, pixel 5 set in bank 1
    rst_n = 1'b1;
    wait_iter(0, c);
    check("f1_fill_cycles", c, PIX + 2);
    check("f1_fill_len", last_len, PIX);
    run_text(3, 0, ns, ni, nl);
    check("f1_starts", ns, 3);
    check("f1_x0", xs[0], 0);
    check("f1_x1", xs[1], 8);
    check("f1_x2", xs[2], 16);
    check("f1_y", ys_or, 0);
    check("f1_iters", ni, 4);
    check("f1_logic_starts", nl, 1);
    run_logic(100, 5);
    repeat (3) @(negedge clk);
    check("f1_done_hold", bus.frame_done, 1);
    do_swap();

    // Frame 2: stray swap during fill, text row overflows after four cells
    wait_iter(3, c);
    check("f2_fill_cycles", c, PIX + 2);
    run_text(8, 0, ns, ni, nl);
    check("f2_starts", ns, 4);
    check("f2_x3", xs[3], 24);
    check("f2_iters", ni, 4);
    check("f2_logic_starts", nl, 1);
    run_logic(10, 9);
    read_check(5, 1, "f2_rd5");
    read_check(6, 0, "f2_rd6");
    read_check(9, 0, "f2_rd9");
    do_swap();

    // Frame 3: front is bank 0 again, then reset in the middle of the text row
    read_check(9, 1, "f3_rd9");
    read_check(5, 0, "f3_rd5");
    bus.read_addr = AW'(9);
    wait_iter(0, c);
    run_text(8, 2, ns, ni, nl);
    check("pre_rst_x", bus.symbol_drawer_x, 8);
    check("pre_rst_rd", bus.read_data, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_x", bus.symbol_drawer_x, 0);
    check("mid_rst_sd_start", bus.symbol_drawer_start, 0);
    check("mid_rst_iter", bus.visible_iter_en, 0);
    check("mid_rst_logic", bus.logic_start, 0);
    check("mid_rst_done", bus.frame_done, 0);
    check("mid_rst_rd", bus.read_data, 0);
    bus.symbol_valid = 1'b0;
    bus.symbol_drawer_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_iter(0, c);
    check("r_fill_cycles", c, PIX + 2);
    check("r_fill_len", last_len, PIX);
    check("fill_order", fill_bad, 0);
    read_check(9, 1, "ram_kept");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
